// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, round constants, GF(2^8) helpers,
// ShiftRows and the controller state type. Used by the encrypt and decrypt paths.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_state_e;

  // Forward S-box, entry 0x00 in the top byte, entry 0xff in the bottom byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[2047 - 8 * int'(b) -: 8];
  endfunction

  // Round constant for rounds 1..10; zero for anything else.
  function automatic logic [7:0] rcon_for_round(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply built from xtime (used by InvMixColumns).
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] pw;
    acc = 8'h00;
    pw  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ pw;
      pw = xtime(pw);
    end
    return acc;
  endfunction

  // Row r of the column-major state rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round plus the matching key-schedule step.
module aes_enc_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] key,
  input  logic [7:0]   rcon,
  input  logic         last_round,
  output logic [127:0] next_state,
  output logic [127:0] next_key
);

  logic [127:0] sub_bytes;
  logic [127:0] shifted;
  logic [127:0] mixed;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  w0, w1, w2, w3;

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Next round key: RotWord/SubWord/Rcon on the last word, then chained XORs.
  always_comb begin
    rot_word = {key[23:0], key[31:24]};
    sub_word = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                sbox(rot_word[15:8]),  sbox(rot_word[7:0])};
    w0 = key[127:96] ^ sub_word ^ {rcon, 24'h000000};
    w1 = key[95:64] ^ w0;
    w2 = key[63:32] ^ w1;
    w3 = key[31:0]  ^ w2;
    next_key = {w0, w1, w2, w3};
  end

  // Data path: SubBytes, ShiftRows, MixColumns (skipped on the last round), AddRoundKey.
  always_comb begin
    sub_bytes = '0;
    for (int i = 0; i < 16; i++) begin
      sub_bytes[127 - 8 * i -: 8] = sbox(state[127 - 8 * i -: 8]);
    end
    shifted = shift_rows(sub_bytes);
    mixed   = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127 - 32 * c -: 32] = mix_column(shifted[127 - 32 * c -: 32]);
    end
    next_state = (last_round ? shifted : mixed) ^ next_key;
  end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock, key expanded on the fly.
// Start handshake: cipher_new_en is a one-cycle strobe with no back-pressure
// signal; it is accepted only when cipher_busy is low (IDLE or DONE) and is
// silently dropped while busy. cipher_ready is a level that stays high until
// the next accepted start or reset.
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter int NR = 10  // AES-128 only
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] plain_text,
  input  logic [127:0] cipher_key,
  input  logic         cipher_new_en,
  output logic [127:0] cipher_text,
  output logic [127:0] round_key_10,
  output logic         cipher_ready,
  output logic         cipher_busy
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  aes_state_e   state;
  logic [127:0] state_reg;
  logic [127:0] key_reg;
  logic [3:0]   rnd;
  logic [127:0] round_state;
  logic [127:0] round_key;

  aes_enc_round u_round (
    .state      (state_reg),
    .key        (key_reg),
    .rcon       (rcon_for_round(rnd)),
    .last_round (rnd == LAST_RND),
    .next_state (round_state),
    .next_key   (round_key)
  );

  // Controller, round counter and all result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      state_reg    <= '0;
      key_reg      <= '0;
      rnd          <= '0;
      cipher_text  <= '0;
      round_key_10 <= '0;
      cipher_ready <= 1'b0;
      cipher_busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (cipher_new_en) begin
            state_reg    <= plain_text ^ cipher_key;
            key_reg      <= cipher_key;
            rnd          <= 4'd1;
            cipher_busy  <= 1'b1;
            cipher_ready <= 1'b0;
            state        <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          if (rnd >= 4'd1 && rnd <= LAST_RND) begin
            state_reg <= round_state;
            key_reg   <= round_key;
            rnd       <= rnd + 4'd1;
            if (rnd == LAST_RND) begin
              cipher_text  <= round_state;
              round_key_10 <= round_key;
              cipher_ready <= 1'b1;
              cipher_busy  <= 1'b0;
              state        <= ST_DONE;
            end
          end else begin
            // Counter outside 1..NR cannot happen; recover to IDLE.
            rnd         <= '0;
            cipher_busy <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Bench for aes_encrypt_iter: FIPS-197 vectors, control corner cases and
// random blocks checked against a byte-array AES reference model.
module tb_aes_encrypt_iter;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_RK  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_RK   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] plain_text;
  logic [127:0] cipher_key;
  logic         cipher_new_en;
  logic [127:0] cipher_text;
  logic [127:0] round_key_10;
  logic         cipher_ready;
  logic         cipher_busy;

  always #5 clk = ~clk;

  aes_encrypt_iter #(.NR(10)) dut (
    .clk           (clk),
    .reset         (reset),
    .plain_text    (plain_text),
    .cipher_key    (cipher_key),
    .cipher_new_en (cipher_new_en),
    .cipher_text   (cipher_text),
    .round_key_10  (round_key_10),
    .cipher_ready  (cipher_ready),
    .cipher_busy   (cipher_busy)
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [127:0] exp_q[$];
  logic [127:0] exp_rk_q[$];

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  sb[256];
  logic [7:0]  isb[256];
  logic [7:0]  rc_tab[11];
  logic [31:0] w[44];
  logic [7:0]  s[16];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v};
    return d[15 - n -: 8];
  endfunction

  // S-box from first principles: multiplicative inverse then affine map.
  function automatic void build_tables();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      b = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sb[x]  = b;
      isb[b] = 8'(x);
    end
    rc_tab[0] = 8'h00;
    rc_tab[1] = 8'h01;
    for (int j = 2; j <= 10; j++) rc_tab[j] = gf_mul(rc_tab[j-1], 8'h02);
  endfunction

  function automatic logic [31:0] key_core(input logic [31:0] t, input int j);
    logic [31:0] r;
    r = {t[23:0], t[31:24]};
    return {sb[r[31:24]], sb[r[23:16]], sb[r[15:8]], sb[r[7:0]]} ^ {rc_tab[j], 24'h000000};
  endfunction

  function automatic void expand_fwd(input logic [127:0] key);
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = key_core(t, i / 4);
      w[i] = w[i-4] ^ t;
    end
  endfunction

  // Run the schedule backwards from the last round key.
  function automatic void expand_back(input logic [127:0] rk);
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[40 + i] = rk[127 - 32 * i -: 32];
    for (int i = 39; i >= 0; i--) begin
      t = w[i+3];
      if ((i + 4) % 4 == 0) t = key_core(t, (i + 4) / 4);
      w[i] = w[i+4] ^ t;
    end
  endfunction

  function automatic void load_blk(input logic [127:0] blk);
    for (int i = 0; i < 16; i++) s[i] = blk[127 - 8 * i -: 8];
  endfunction

  function automatic logic [127:0] pack_blk();
    logic [127:0] blk;
    for (int i = 0; i < 16; i++) blk[127 - 8 * i -: 8] = s[i];
    return blk;
  endfunction

  function automatic void add_key(input int rd);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r + 4 * c] = s[r + 4 * c] ^ w[4 * rd + c][31 - 8 * r -: 8];
  endfunction

  function automatic void shift(input bit inverse);
    logic [7:0] t[16];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[r + 4 * c] = inverse ? s[r + 4 * ((c - r + 4) % 4)] : s[r + 4 * ((c + r) % 4)];
    s = t;
  endfunction

  function automatic void mix(input bit inverse);
    logic [7:0] a0, a1, a2, a3, m0, m1, m2, m3;
    m0 = inverse ? 8'h0e : 8'h02;
    m1 = inverse ? 8'h0b : 8'h03;
    m2 = inverse ? 8'h0d : 8'h01;
    m3 = inverse ? 8'h09 : 8'h01;
    for (int c = 0; c < 4; c++) begin
      a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
      s[4*c]   = gf_mul(m0, a0) ^ gf_mul(m1, a1) ^ gf_mul(m2, a2) ^ gf_mul(m3, a3);
      s[4*c+1] = gf_mul(m3, a0) ^ gf_mul(m0, a1) ^ gf_mul(m1, a2) ^ gf_mul(m2, a3);
      s[4*c+2] = gf_mul(m2, a0) ^ gf_mul(m3, a1) ^ gf_mul(m0, a2) ^ gf_mul(m1, a3);
      s[4*c+3] = gf_mul(m1, a0) ^ gf_mul(m2, a1) ^ gf_mul(m3, a2) ^ gf_mul(m0, a3);
    end
  endfunction

  function automatic void model_encrypt(input logic [127:0] pt, input logic [127:0] key,
                                        output logic [127:0] ct, output logic [127:0] rk);
    expand_fwd(key);
    load_blk(pt);
    add_key(0);
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      shift(1'b0);
      if (rd < 10) mix(1'b0);
      add_key(rd);
    end
    ct = pack_blk();
    rk = {w[40], w[41], w[42], w[43]};
  endfunction

  function automatic logic [127:0] model_decrypt(input logic [127:0] ct, input logic [127:0] rk);
    expand_back(rk);
    load_blk(ct);
    add_key(10);
    for (int rd = 9; rd >= 0; rd--) begin
      shift(1'b1);
      for (int i = 0; i < 16; i++) s[i] = isb[s[i]];
      add_key(rd);
      if (rd > 0) mix(1'b1);
    end
    return pack_blk();
  endfunction

  // ---------------- driver tasks ----------------
  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_block(input logic [127:0] pt, input logic [127:0] key);
    plain_text    = pt;
    cipher_key    = key;
    cipher_new_en = 1'b1;
    tick();
    cipher_new_en = 1'b0;
    plain_text    = rand128();
    cipher_key    = rand128();
  endtask

  // Wait for cipher_ready; optionally pulse a stray start after inject_at cycles.
  task automatic wait_ready(input int inject_at, inout int cycles, inout bit busy_ok);
    while (!cipher_ready && cycles < 40) begin
      if (!cipher_busy) busy_ok = 1'b0;
      if (cycles == inject_at) begin
        plain_text    = B_PT;
        cipher_key    = B_KEY;
        cipher_new_en = 1'b1;
      end
      tick();
      cipher_new_en = 1'b0;
      cycles++;
    end
  endtask

  task automatic run_and_check(input string tag, input logic [127:0] pt,
                               input logic [127:0] key, input int inject_at);
    int cycles;
    bit busy_ok;
    logic [127:0] ct_m, rk_m;
    model_encrypt(pt, key, ct_m, rk_m);
    exp_q.push_back(ct_m);
    exp_rk_q.push_back(rk_m);
    start_block(pt, key);
    cycles  = 0;
    busy_ok = 1'b1;
    wait_ready(inject_at, cycles, busy_ok);
    check_val({tag, "_latency"}, 128'(cycles), 128'd10);
    check_val({tag, "_busy_run"}, 128'(busy_ok), 128'd1);
    check_val({tag, "_busy_done"}, 128'(cipher_busy), 128'd0);
    check_val({tag, "_ct"}, cipher_text, exp_q.pop_front());
    check_val({tag, "_rk10"}, round_key_10, exp_rk_q.pop_front());
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int  cycles;
    bit  busy_ok;
    bit  seen;
    reset         = 1'b1;
    cipher_new_en = 1'b0;
    plain_text    = '0;
    cipher_key    = '0;
    build_tables();
    repeat (3) tick();

    check_val("rst_ct", cipher_text, '0);
    check_val("rst_rk10", round_key_10, '0);
    check_val("rst_ready", 128'(cipher_ready), '0);
    check_val("rst_busy", 128'(cipher_busy), '0);
    reset = 1'b0;
    tick();

    // FIPS-197 C.1 and Appendix B known answers.
    run_and_check("c1", C1_PT, C1_KEY, -1);
    check_val("c1_kat_ct", cipher_text, C1_CT);
    check_val("c1_kat_rk10", round_key_10, C1_RK);
    check_val("loopback_pt", model_decrypt(cipher_text, round_key_10), C1_PT);
    repeat (2) tick();
    run_and_check("appb", B_PT, B_KEY, -1);
    check_val("appb_kat_ct", cipher_text, B_CT);
    check_val("appb_kat_rk10", round_key_10, B_RK);

    // Stray start (App. B data) during a C.1 run must be ignored.
    tick();
    run_and_check("ign", C1_PT, C1_KEY, 3);
    check_val("ign_kat_ct", cipher_text, C1_CT);

    // Back-to-back: new start on the first edge after completion.
    start_block(B_PT, B_KEY);
    check_val("b2b_ready_drop", 128'(cipher_ready), '0);
    check_val("b2b_hold_ct", cipher_text, C1_CT);
    check_val("b2b_hold_rk10", round_key_10, C1_RK);
    cycles  = 0;
    busy_ok = 1'b1;
    repeat (5) begin
      tick();
      cycles++;
    end
    check_val("b2b_mid_ct", cipher_text, C1_CT);
    wait_ready(-1, cycles, busy_ok);
    check_val("b2b_latency", 128'(cycles), 128'd10);
    check_val("b2b_ct", cipher_text, B_CT);
    check_val("b2b_rk10", round_key_10, B_RK);

    // Reset during round 5 aborts the block.
    start_block(C1_PT, C1_KEY);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    check_val("abort_ct", cipher_text, '0);
    check_val("abort_rk10", round_key_10, '0);
    check_val("abort_ready", 128'(cipher_ready), '0);
    check_val("abort_busy", 128'(cipher_busy), '0);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (15) begin
      tick();
      if (cipher_ready) seen = 1'b1;
    end
    check_val("abort_no_ready", 128'(seen), '0);
    run_and_check("post_abort", C1_PT, C1_KEY, -1);
    check_val("post_abort_kat", cipher_text, C1_CT);

    // Random blocks with random gaps and occasional stray starts.
    for (int n = 0; n < 20; n++) begin
      int gap;
      int inj;
      gap = $urandom_range(0, 2);
      inj = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 8) : -1;
      repeat (gap) tick();
      run_and_check("rand", rand128(), rand128(), inj);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
